// File: rtl/keypad_display_scanner.sv
// keypad_display_scanner: keypad entry buffer multiplexed onto NUM_DIGITS seven-segment digits.
// Optional blink blanking is built only when DISPLAY_BLINK_EN is defined.
`default_nettype none

module keypad_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = 3,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [3:0]            i_digit,
  input  logic                  i_clear,
  input  logic                  i_blink,
  output logic [3:0]            o_binary,
  output logic                  o_en,
  output logic [NUM_DIGITS-1:0] o_digit_sel,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full
);

  localparam int              PRE_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_DIGITS);

  logic [3:0]       entries [NUM_DIGITS];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] idx;
  logic [PRE_W-1:0] prescale;
  logic             full;
  logic             blank;

  assign full = (count == FULL_CNT);

  // Clear beats push; a push into a full buffer is dropped without wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) entries[k] <= 4'h0;
      count <= '0;
    end else if (i_clear) begin
      for (int k = 0; k < NUM_DIGITS; k++) entries[k] <= 4'h0;
      count <= '0;
    end else if (i_push && !full) begin
      entries[0] <= i_digit;
      for (int k = 1; k < NUM_DIGITS; k++) entries[k] <= entries[k-1];
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prescale <= '0;
      idx      <= '0;
    end else begin
      if (prescale >= PRE_LAST) prescale <= '0;
      else                      prescale <= prescale + 1'b1;

      if (idx > LAST_IDX)
        idx <= '0;
      else if (prescale >= PRE_LAST)
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int              BLK_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  // Held at zero while idle so every blink request opens with a visible half-period.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_blink) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt >= BLK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blank = i_blink & blink_phase;
`else
  logic unused_blink;
  assign unused_blink = i_blink ^ (BLINK_DIV == 0);
  assign blank        = 1'b0;
`endif

  always_comb begin
    o_digit_sel = '1;
    o_binary    = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == CNT_W'(k)) begin
        o_digit_sel[k] = 1'b0;
        o_binary       = entries[k];
      end
    end
  end

  assign o_en    = (idx < count) && !blank;
  assign o_count = count;
  assign o_full  = full;

endmodule

`default_nettype wire

// File: doc/keypad_display_scanner.md
Name: keypad_display_scanner

Overview:
- Sits directly upstream of the seven-segment decoder in the door-lock display path.
- Collects keypad digits into an entry buffer that shifts in from the right.
- Time-multiplexes the buffer across NUM_DIGITS common-anode displays, driving one shared decoder through o_binary/o_en and selecting the lit digit through o_digit_sel.
- Also reports the entry count and a full flag to the lock controller.

Parameters:
- NUM_DIGITS, 4, number of display digits / entry buffer depth (2..7).
- CNT_W, 3, width of o_count; must satisfy 2^CNT_W > NUM_DIGITS.
- SCAN_DIV, 50000, clock cycles each digit stays selected (>= 2).
- BLINK_DIV, 12500000, clock cycles per blink half-period; used only with DISPLAY_BLINK_EN.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- i_push  input  1  single-cycle strobe: append i_digit to the buffer.
- i_digit  input  4  keypad value (0x0..0xF), sampled when i_push=1.
- i_clear  input  1  single-cycle strobe: empty the buffer.
- i_blink  input  1  blink request; functional only with DISPLAY_BLINK_EN.
- o_binary  output  4  value of the currently scanned digit, to the decoder.
- o_en  output  1  decoder enable; 0 = blank the scanned digit.
- o_digit_sel  output  NUM_DIGITS  active-low one-hot digit select; bit k = position k, 0 = rightmost.
- o_count  output  CNT_W  number of digits entered, 0..NUM_DIGITS.
- o_full  output  1  1 when o_count == NUM_DIGITS.

Behaviour:
- All state updates on the rising edge of i_clk.
- When i_rst_n=0 at an edge, the block enters its reset state:
  - all buffer entries 0; count 0; scan index 0; prescaler 0; blink state 0.
  - outputs: o_digit_sel = all ones except bit0=0; o_en=0; o_binary=0; o_count=0; o_full=0.
- Reset overrides i_push and i_clear in the same cycle.
- Buffer push:
  - i_push=1 and count<NUM_DIGITS: entries shift one position left (entry k takes entry k-1); entry 0 takes i_digit; count increments.
  - i_push=1 while full: ignored entirely; buffer and count unchanged; no wrap.
- Buffer clear:
  - i_clear=1: all entries set to 0, count set to 0.
  - i_clear and i_push in the same cycle: clear wins; the pushed digit is discarded.
- Update visibility:
  - o_count and o_full are registered and reflect a push or clear on the edge that samples it.
  - Display outputs reflect new buffer contents in the same cycle the buffer updates.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On the wrap edge, the scan index advances by 1 and wraps NUM_DIGITS-1 -> 0.
  - Each digit is therefore selected for exactly SCAN_DIV cycles.
  - Push and clear do not disturb the prescaler or scan index.
- Display outputs are combinational from registered state only (scan index, buffer, count, blink state), so they are glitch-free at register granularity:
  - o_digit_sel: bit[idx]=0, all other bits 1.
  - o_binary = entry[idx].
  - o_en = 1 iff idx < count (and blink not blanking); unentered positions are blank.
- Reachable state:
  - No illegal scan index is reachable.
  - If the index register ever holds a value >= NUM_DIGITS, the next edge forces it to 0.

Optional Feature:
- Macro: DISPLAY_BLINK_EN.
- Defined:
  - A BLINK_DIV cycle counter toggles a blink phase bit on each wrap.
  - While i_blink=1 and the phase bit is 1, o_en is forced to 0 for all digits; scanning continues.
  - When i_blink=0, the blink counter and phase are held at 0, so each blink starts with a visible half-period.
- Undefined:
  - i_blink is present but ignored; no blink counter is synthesised.
  - o_en depends only on idx < count.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with i_push=1, i_digit=7 -> o_count=0, o_full=0, o_en=0, o_binary=0, o_digit_sel=4'b1110 throughout, and for the first cycle after release.
- Entry, SCAN_DIV=4, NUM_DIGITS=4: push 1, 2, 3 -> o_count=3; while idx=2,1,0, o_binary=1,2,3 with o_en=1; while idx=3, o_en=0.
- Full: push 4 then 5 -> o_count=4, o_full=1; scanning idx 3..0 shows 1,2,3,4; digit 5 never appears.
- Clear priority: with 4 digits stored, assert i_clear and i_push (digit 9) in the same cycle -> next cycle o_count=0, o_full=0, o_en=0 on all positions, all entries 0.
- Scan timing, SCAN_DIV=4: from reset, o_digit_sel is 1110 for cycles 0-3, 1101 for 4-7, 1011 for 8-11, 0111 for 12-15, then back to 1110 at cycle 16; a push at cycle 6 does not shift this sequence.
- Blink, with DISPLAY_BLINK_EN, BLINK_DIV=8, 2 digits stored, i_blink=1 -> o_en is 0 for all positions during alternating 8-cycle windows; i_blink=0 restores normal o_en immediately. Without the macro, the same stimulus shows no blanking.
